// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB/TRAP with ready handshakes.
// Optional retire counter output enabled by the RETIRE_COUNT_EN macro.
module multicycle_ctrl (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        ALUzero,
    input  logic        ALUlsb,
    output logic        IRwrite,
    output logic        ALUcontrol,
    output logic        IRtype,
    output logic        BranchEn,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        PCwrite,
    output logic [1:0]  PCsel,
    output logic        retire,
    output logic        illegal
`ifdef RETIRE_COUNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    function automatic logic legal_op(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal_op = 1'b1;
            default:                           legal_op = 1'b0;
        endcase
    endfunction

    // funct3 010/011 are not branch encodings and never redirect the PC
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero, input logic lsb);
        case (f3)
            3'b000:         branch_taken = zero;
            3'b001:         branch_taken = ~zero;
            3'b100, 3'b110: branch_taken = lsb;
            3'b101, 3'b111: branch_taken = ~lsb;
            default:        branch_taken = 1'b0;
        endcase
    endfunction

    logic [2:0] state_r;
    logic [2:0] state_next_s;
    logic       illegal_r;
    logic       is_load_s;
    logic       is_store_s;
    logic       is_branch_s;
    logic       is_alu_r_s;
    logic       is_alu_i_s;
    logic       taken_s;

    assign is_load_s   = (opcode == OP_LOAD);
    assign is_store_s  = (opcode == OP_STORE);
    assign is_branch_s = (opcode == OP_BRANCH);
    assign is_alu_r_s  = (opcode == OP_R);
    assign is_alu_i_s  = (opcode == OP_I);
    assign taken_s     = branch_taken(funct3, ALUzero, ALUlsb);
    assign illegal     = illegal_r;

    // Next-state selection
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (imem_ready) state_next_s = S_DECODE;
                else            state_next_s = S_FETCH;
            end
            S_DECODE: begin
                if (legal_op(opcode)) state_next_s = S_EXEC;
                else                  state_next_s = S_TRAP;
            end
            S_EXEC: begin
                if (is_load_s || is_store_s) state_next_s = S_MEM;
                else if (is_branch_s)        state_next_s = S_FETCH;
                else                         state_next_s = S_WB;
            end
            S_MEM: begin
                if (!dmem_ready)    state_next_s = S_MEM;
                else if (is_load_s) state_next_s = S_WB;
                else                state_next_s = S_FETCH;
            end
            S_WB:    state_next_s = S_FETCH;
            S_TRAP:  state_next_s = S_TRAP;
            default: state_next_s = S_FETCH;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state_r <= S_FETCH;
        else         state_r <= state_next_s;
    end

    // Sticky illegal flag, raised as DECODE hands over to TRAP
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)                                     illegal_r <= 1'b0;
        else if (state_r == S_DECODE && !legal_op(opcode)) illegal_r <= 1'b1;
        else                                             illegal_r <= illegal_r;
    end

    // Output decode; gated by RESETn so strobes clear the moment reset is applied
    always_comb begin
        IRwrite    = 1'b0;
        ALUcontrol = 1'b0;
        IRtype     = 1'b0;
        BranchEn   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        PCwrite    = 1'b0;
        PCsel      = 2'b00;
        retire     = 1'b0;
        if (RESETn) begin
            case (state_r)
                S_FETCH: IRwrite = imem_ready;
                S_EXEC: begin
                    ALUcontrol = is_alu_r_s | is_alu_i_s;
                    IRtype     = is_alu_i_s;
                    BranchEn   = is_branch_s;
                    if (is_branch_s) begin
                        PCwrite = 1'b1;
                        retire  = 1'b1;
                        PCsel   = taken_s ? 2'b01 : 2'b00;
                    end else begin
                        PCwrite = 1'b0;
                    end
                end
                S_MEM: begin
                    MemRead  = is_load_s;
                    MemWrite = ~is_load_s;
                    if (!is_load_s && dmem_ready) begin
                        PCwrite = 1'b1;
                        retire  = 1'b1;
                    end else begin
                        PCwrite = 1'b0;
                    end
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    PCwrite  = 1'b1;
                    retire   = 1'b1;
                    if (opcode == OP_JAL)       PCsel = 2'b01;
                    else if (opcode == OP_JALR) PCsel = 2'b10;
                    else                        PCsel = 2'b00;
                end
                default: IRwrite = 1'b0;
            endcase
        end else begin
            IRwrite = 1'b0;
        end
    end

`ifdef RETIRE_COUNT_EN
    logic [31:0] retire_cnt_r;

    // Retired-instruction counter, wraps naturally at 32 bits
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)     retire_cnt_r <= 32'd0;
        else if (retire) retire_cnt_r <= retire_cnt_r + 32'd1;
        else             retire_cnt_r <= retire_cnt_r;
    end

    assign retire_cnt = retire_cnt_r;
`endif

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 CLK  input  1  single system clock; all state updates on rising edge.
REQ-002 RESETn  input  1  asynchronous, active-low reset.
REQ-003 opcode  input  7  IR[6:0] of the latched instruction.
REQ-004 funct3  input  3  IR[14:12]; used for branch resolution.
REQ-005 imem_ready  input  1  instruction memory data valid.
REQ-006 dmem_ready  input  1  data memory access complete.
REQ-007 ALUzero  input  1  ALU result == 0.
REQ-008 ALUlsb  input  1  ALU result bit 0 (SLT/SLTU outcome).
REQ-009 IRwrite  output  1  load instruction register.
REQ-010 ALUcontrol  output  1  ALU operation taken from funct3.
REQ-011 IRtype  output  1  1 = I-type computational; 0 = R-type.
REQ-012 BranchEn  output  1  branch compare operation.
REQ-013 MemRead / MemWrite  output  1 each  data memory strobes.
REQ-014 RegWrite  output  1  register file write enable.
REQ-015 PCwrite  output  1  PC update strobe; 1-cycle pulse.
REQ-016 PCsel  output  2  00 PC+4; 01 PC+imm; 10 ALU result (JALR).
REQ-017 retire  output  1  1-cycle pulse, instruction complete.
REQ-018 illegal  output  1  sticky unsupported-opcode flag.

Function
REQ-019 States: FETCH, DECODE, EXEC, MEM, WB, TRAP; one-hot or binary encoding at implementer's choice.
REQ-020 FETCH: IRwrite=imem_ready; the FSM stays in FETCH while imem_ready=0 and moves to DECODE when imem_ready=1.
REQ-021 DECODE: all strobes 0; next state is EXEC for opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, and TRAP for any other opcode.
REQ-022 EXEC drives ALUcontrol=1 for R/I-ALU, IRtype=1 for I-ALU, BranchEn=1 for branch, and all three 0 for the other opcodes (default ADD).
REQ-023 EXEC exit: load/store go to MEM; branch retires in EXEC and goes to FETCH; all other opcodes go to WB.
REQ-024 Branch taken = BEQ:ALUzero, BNE:!ALUzero, BLT/BLTU:ALUlsb, BGE/BGEU:!ALUlsb (funct3 010/011 never taken); PCsel=01 if taken, else 00.
REQ-025 MEM: MemRead (load) or MemWrite (store) asserted and held until dmem_ready=1; load then goes to WB; store retires in MEM and goes to FETCH.
REQ-026 WB: RegWrite=1; PCsel=01 for JAL, 10 for JALR, 00 otherwise; then FETCH.
REQ-027 The retire cycle asserts PCwrite=1 and retire=1 together for exactly one cycle; PCwrite is 0 in all other cycles.
REQ-028 Minimum latency FETCH to retire: branch 3 cycles, store 4, R/I/LUI/AUIPC/JAL/JALR 4, load 5; each cycle of ready=0 adds one cycle.
REQ-029 TRAP: all strobes 0, illegal=1; TRAP is absorbing until reset.
REQ-030 All outputs except illegal are Moore functions of the state and the latched opcode/funct3; in FETCH and MEM they also depend on the ready inputs.

Reset
REQ-031 When RESETn=0: state=FETCH, illegal=0, all strobes 0, PCsel=00, asynchronously and independent of CLK.
REQ-032 A reset asserted mid-instruction (including during a stalled MEM) abandons the instruction with no PCwrite and no retire.

Configuration
REQ-033 Macro RETIRE_COUNT_EN, when defined, adds output retire_cnt[31:0], which resets to 0, increments on each retire pulse, and wraps from 0xFFFFFFFF to 0.
REQ-034 When RETIRE_COUNT_EN is not defined, the port and counter are absent and all other behaviour is identical.

Verification
REQ-035 R-type ADD with imem/dmem ready=1 -> FETCH, DECODE, EXEC (ALUcontrol=1, IRtype=0), WB (RegWrite=1, PCwrite=1, PCsel=00); retire at cycle 4.
REQ-036 Load with dmem_ready low for 3 cycles -> MemRead held 4 cycles, RegWrite in WB, retire at cycle 8.
REQ-037 BNE, ALUzero=0 -> BranchEn=1, PCsel=01, PCwrite=1 in EXEC, retire at cycle 3; BGE with ALUlsb=1 -> PCsel=00.
REQ-038 Opcode 1111111 -> TRAP after DECODE, illegal=1 stays set for 100 cycles, no retire; RESETn low clears illegal and returns to FETCH.
REQ-039 RESETn pulsed low during a stalled store MEM -> MemWrite drops immediately, no retire; with RETIRE_COUNT_EN defined, retire_cnt=0.
REQ-040 With RETIRE_COUNT_EN defined and counter forced to 0xFFFFFFFF -> the next retire gives retire_cnt=0.
